// File: rtl/pc_next_ctrl.sv
// ---------------------------------------------------------------------------
// pc_next_ctrl
// Next-PC sequencer for the fetch-stage PC register. Holds a direct-mapped
// branch target buffer with 2-bit saturating counters, produces the predicted
// next PC every cycle, and turns mispredictions resolved in EX into a
// redirect (pc_sel/adin), a flush and a run of post-redirect bubble cycles.
//
// Optional feature: define PC_NEXT_CTRL_STATS_EN to add the saturating
// stat_branches / stat_mispred counters and their output ports.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   fetch_pc          current PC register value (word address)
//   load_use_hazard   stall request from the hazard unit
//   ex_valid          EX-stage instruction valid
//   ex_is_branch      EX instruction is a branch/jump
//   ex_pc             EX instruction word address
//   ex_taken          resolved direction
//   ex_target         resolved target
//   ex_pred_taken     prediction carried down the pipe
//   ex_pred_target    predicted target carried down the pipe
//   predict_pc        predicted next PC for fetch_pc
//   pred_taken        BTB predicts taken for fetch_pc
//   pc_sel            PC register loads adin
//   adin              redirect address
//   hazard            freeze PC (load-use stall)
//   branch_bubble     freeze PC after a redirect
//   flush             squash IF/ID and ID/EX
//   stat_branches     (stats build) evaluated branch count, saturating
//   stat_mispred      (stats build) mispredict count, saturating
// ---------------------------------------------------------------------------
module pc_next_ctrl #(
   parameter int          BTB_IDX_W  = 4,
   parameter int          BUBBLE_CYC = 1,
   parameter logic [29:0] RESET_PC   = 30'h00000C0D
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [29:0] fetch_pc,
   input  logic        load_use_hazard,
   input  logic        ex_valid,
   input  logic        ex_is_branch,
   input  logic [29:0] ex_pc,
   input  logic        ex_taken,
   input  logic [29:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [29:0] ex_pred_target,
   output logic [29:0] predict_pc,
   output logic        pred_taken,
   output logic        pc_sel,
   output logic [29:0] adin,
   output logic        hazard,
   output logic        branch_bubble,
   output logic        flush
`ifdef PC_NEXT_CTRL_STATS_EN
   ,
   output logic [15:0] stat_branches,
   output logic [15:0] stat_mispred
`endif
);

   localparam int N_ENT = 1 << BTB_IDX_W;
   localparam int TAG_W = 30 - BTB_IDX_W;
   localparam logic [2:0] BUB_INIT = (BUBBLE_CYC > 0) ? 3'(BUBBLE_CYC - 1) : 3'd0;

   typedef enum logic [1:0] {RUN, REDIRECT, BUBBLE} state_t;

   state_t state, state_nxt;
   logic [29:0] redir_q;
   logic [2:0]  bub_cnt;

   logic [N_ENT-1:0] btb_valid;
   logic [TAG_W-1:0] btb_tag [N_ENT];
   logic [29:0]      btb_tgt [N_ENT];
   logic [1:0]       btb_ctr [N_ENT];

   logic [BTB_IDX_W-1:0] f_idx, e_idx;
   logic [TAG_W-1:0]     f_tag, e_tag;
   logic                 f_hit, e_hit;
   logic                 ex_eval, mispredict;
   logic [29:0]          correct_pc;

   assign f_idx = fetch_pc[BTB_IDX_W-1:0];
   assign f_tag = fetch_pc[29:BTB_IDX_W];
   assign e_idx = ex_pc[BTB_IDX_W-1:0];
   assign e_tag = ex_pc[29:BTB_IDX_W];

   // Fetch-side lookup reads the registered table, so a same-cycle update to
   // the same entry is only visible from the next cycle on.
   always_comb begin
      f_hit      = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
      pred_taken = f_hit && btb_ctr[f_idx][1];
      predict_pc = pred_taken ? btb_tgt[f_idx] : fetch_pc + 30'd1;
   end

   // EX-side resolution. Only an instruction seen while running counts; the
   // redirect and bubble cycles carry squashed work that must be ignored.
   always_comb begin
      e_hit      = btb_valid[e_idx] && (btb_tag[e_idx] == e_tag);
      ex_eval    = (state == RUN) && ex_valid;
      mispredict = 1'b0;
      if (ex_eval) begin
         if (ex_is_branch)
            mispredict = (ex_taken != ex_pred_taken) ||
                         (ex_taken && (ex_target != ex_pred_target));
         else
            mispredict = ex_pred_taken;
      end
      correct_pc = (ex_is_branch && ex_taken) ? ex_target : ex_pc + 30'd1;
   end

   // Sequencer next-state and control outputs. The redirect cycle drives the
   // PC unconditionally, which is why hazard is held low there.
   always_comb begin
      state_nxt     = state;
      pc_sel        = 1'b0;
      hazard        = 1'b0;
      branch_bubble = 1'b0;
      flush         = 1'b0;
      case (state)
         RUN: begin
            hazard = load_use_hazard;
            if (mispredict) begin
               flush     = 1'b1;
               state_nxt = REDIRECT;
            end
         end
         REDIRECT: begin
            pc_sel    = 1'b1;
            flush     = 1'b1;
            state_nxt = (BUBBLE_CYC > 0) ? BUBBLE : RUN;
         end
         BUBBLE: begin
            branch_bubble = 1'b1;
            if (bub_cnt == 3'd0)
               state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   assign adin = redir_q;

   // State register, redirect latch and bubble countdown. The counter is
   // loaded on the way into BUBBLE so BUBBLE lasts exactly BUBBLE_CYC cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= RUN;
         redir_q <= RESET_PC;
         bub_cnt <= 3'd0;
      end else begin
         state <= state_nxt;
         if (mispredict)
            redir_q <= correct_pc;
         if (state == REDIRECT)
            bub_cnt <= BUB_INIT;
         else if ((state == BUBBLE) && (bub_cnt != 3'd0))
            bub_cnt <= bub_cnt - 3'd1;
      end
   end

   // BTB training. Taken misses allocate weakly-taken; a non-branch that
   // aliases onto a live entry invalidates it so it stops predicting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btb_valid <= '0;
         for (int i = 0; i < N_ENT; i++) begin
            btb_ctr[i] <= 2'b01;
            btb_tag[i] <= '0;
            btb_tgt[i] <= '0;
         end
      end else if (ex_eval) begin
         if (ex_is_branch) begin
            if (e_hit) begin
               if (ex_taken) begin
                  btb_tgt[e_idx] <= ex_target;
                  if (btb_ctr[e_idx] != 2'b11)
                     btb_ctr[e_idx] <= btb_ctr[e_idx] + 2'b01;
               end else if (btb_ctr[e_idx] != 2'b00) begin
                  btb_ctr[e_idx] <= btb_ctr[e_idx] - 2'b01;
               end
            end else if (ex_taken) begin
               btb_valid[e_idx] <= 1'b1;
               btb_tag[e_idx]   <= e_tag;
               btb_tgt[e_idx]   <= ex_target;
               btb_ctr[e_idx]   <= 2'b10;
            end
         end else if (e_hit) begin
            btb_valid[e_idx] <= 1'b0;
         end
      end
   end

`ifdef PC_NEXT_CTRL_STATS_EN
   // Saturating event counters for branch and mispredict statistics.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_branches <= 16'd0;
         stat_mispred  <= 16'd0;
      end else begin
         if (ex_eval && ex_is_branch && (stat_branches != 16'hFFFF))
            stat_branches <= stat_branches + 16'd1;
         if (mispredict && (stat_mispred != 16'hFFFF))
            stat_mispred <= stat_mispred + 16'd1;
      end
   end
`endif

endmodule
